uart_tx_queue: RTL and testbench

//   Byte queue feeding the board UART transmit port (txdata/txclk/txready) of the top design.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 97 +++++++++
 rtl/uart_tx_queue.sv | 122 ++++++++++++
 tb/tb_uart_tx_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and defaults for the UART transmit queue.
//   - byte_t      : one transmitted byte
//   - tx_state_t  : handshake FSM states (IDLE, STROBE, WAIT_BUSY, WAIT_READY)
//   - DEFAULT_DEPTH / DEFAULT_BUSY_TIMEOUT : parameter defaults
//   - timer_width() : bits needed to count 0..BUSY_TIMEOUT
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STROBE     = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } tx_state_t;

  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

  // Width of a counter that must reach the value t (at least 1 bit).
  function automatic int timer_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy and a sticky overflow flag.
//   The head entry is read combinationally so a consumer can capture it on
//   the same edge that pops it.
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   push      in   write wr_data this cycle (ignored while full)
//   wr_data   in   WIDTH-bit data to store
//   pop       in   remove head entry this cycle (ignored while empty)
//   head      out  data at the read pointer
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   count     out  occupancy, $clog2(DEPTH)+1 bits
//   overflow  out  sticky: a push arrived while full
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Flags come from registered occupancy only; a pop in the same cycle does
  // not make room for a push.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (push && full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//   Byte queue in front of the board UART transmitter. Bytes pushed by user
//   logic are buffered in a FIFO and handed to the transmitter one at a time
//   with a one-cycle txclk strobe, then the block waits for the transmitter
//   to go busy (or a short timeout) and become ready again.
// Ports
//   hz100     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   wr_en     in   push wr_data this cycle
//   wr_data   in   byte to enqueue
//   full      out  queue holds DEPTH bytes; pushes are dropped
//   empty     out  queue holds no bytes
//   count     out  occupancy
//   overflow  out  sticky: a push was dropped
//   txdata    out  byte presented to the transmitter
//   txclk     out  one-cycle start strobe
//   txready   in   1 = transmitter idle, 0 = shifting
// ---------------------------------------------------------------------------
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             txdata,
  output logic                   txclk,
  input  logic                   txready
);

  localparam int TW = timer_width(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT);

  tx_state_t     state_q, state_d;
  byte_t         txdata_q, txdata_d;
  logic          txclk_q, txclk_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pop;
  byte_t         head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (hz100),
    .rst_n    (reset),
    .push     (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    state_d  = state_q;
    txdata_d = txdata_q;
    txclk_d  = 1'b0;
    timer_d  = timer_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        // The head byte is captured and popped on the same edge that
        // raises the strobe.
        if (!empty && txready) begin
          pop      = 1'b1;
          txdata_d = head;
          txclk_d  = 1'b1;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A transmitter fast enough never to show busy is released by the
        // timer, which lets WAIT_BUSY last BUSY_TIMEOUT+1 cycles.
        if (!txready) begin
          state_d = WAIT_READY;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = WAIT_READY;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_READY: begin
        if (txready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      timer_q  <= timer_d;
    end
  end

  assign txdata = txdata_q;
  assign txclk  = txclk_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
//   Self-checking bench for uart_tx_queue (DEPTH=8, BUSY_TIMEOUT=4):
//   reset, single byte latency, burst/overflow vector table, timeout
//   spacing, mid-transfer reset, and a randomized run against a queue model.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int BT    = 4;

  logic       hz100 = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .hz100    (hz100),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready)
  );

  always #5 hz100 = ~hz100;
  always @(posedge hz100) cyc <= cyc + 1;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       txclk;
    logic [7:0] txdata;
  } vec_t;

  vec_t tbl[14];

  // Reference queue for the randomized run.
  logic [7:0] q[$];
  logic       ovf_m;
  int         busy_left;
  int         last_strobe;

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic rdy,
                              input logic [3:0] c, input logic e, input logic f,
                              input logic o, input logic s, input logic [7:0] td);
    vec_t v;
    v.we = we; v.wd = wd; v.rdy = rdy; v.count = c; v.empty = e;
    v.full = f; v.ovf = o; v.txclk = s; v.txdata = td;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {16'h0, count, empty, full, overflow, txclk, txdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hz100);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (txclk === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    txready = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  // One randomized cycle: drive, step, then compare against the queue model.
  task automatic rnd_cycle(input bit allow_push);
    int         occ_before;
    logic       we;
    logic [7:0] wd;
    logic [7:0] exp_b;
    we      = allow_push && ($urandom_range(0, 99) < 45);
    wd      = 8'($urandom);
    wr_en   = we;
    wr_data = wd;
    occ_before = q.size();
    step();
    if (txclk === 1'b1) begin
      check("rnd strobe_nonempty", 32'(occ_before > 0), 32'd1);
      check("rnd strobe_spacing", 32'((cyc - last_strobe) >= 4), 32'd1);
      last_strobe = cyc;
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        check("rnd txdata", 32'(txdata), 32'(exp_b));
      end
    end
    if (we) begin
      if (occ_before < DEPTH) q.push_back(wd);
      else ovf_m = 1'b1;
    end
    check("rnd status", {24'h0, count, empty, full, overflow, 1'b0},
          {24'h0, 4'(q.size()), q.size() == 0, q.size() == DEPTH, ovf_m, 1'b0});
    // Transmitter model: after a strobe it either goes busy for a few
    // cycles or stays ready (exercising the timeout path).
    if (txclk === 1'b1)
      busy_left = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
    if (busy_left > 0) begin
      txready = 1'b0;
      busy_left--;
    end else begin
      txready = 1'b1;
    end
  endtask

  initial begin
    bit got;
    int t1;
    int nstrobe;

    // ---- 1: reset held with wr_en=1 ----
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    txready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("reset_hold[%0d]", i), outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    wr_en = 1'b0;
    reset = 1'b1;
    step();
    check("reset_release", outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // ---- 2: single byte, latency 2 ----
    wr_en   = 1'b1;
    wr_data = 8'h41;
    txready = 1'b1;
    step();
    wr_en = 1'b0;
    check("single_after_push", outs(), {16'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    step();
    check("single_strobe", outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41});
    txready = 1'b0;
    nstrobe = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (txclk !== 1'b0) nstrobe++;
    end
    check("single_no_restrobe", 32'(nstrobe), 32'd0);
    check("single_txdata_hold", 32'(txdata), 32'h41);
    txready = 1'b1;
    step();
    step();
    check("single_idle", outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41});

    // ---- 3/4: burst fill, overflow, drop-while-popping (vector table) ----
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, 8'h30 + 8'(i), 1'b0, 4'(i + 1), 1'b0, (i == 7), 1'b0, 1'b0, 8'h00);
    tbl[8]  = mk(1'b1, 8'hFF, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl[9]  = mk(1'b1, 8'hEE, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    tbl[11] = mk(1'b0, 8'h00, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    tbl[13] = mk(1'b0, 8'h00, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h31);

    do_reset();
    txready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wr_en   = tbl[i].we;
      wr_data = tbl[i].wd;
      txready = tbl[i].rdy;
      step();
      check($sformatf("tbl[%0d] (count,empty,full,ovf,txclk,txdata)", i), outs(),
            {16'h0, tbl[i].count, tbl[i].empty, tbl[i].full, tbl[i].ovf,
             tbl[i].txclk, tbl[i].txdata});
    end
    wr_en = 1'b0;
    for (int k = 2; k < 8; k++) begin
      txready = 1'b0;
      step();
      step();
      txready = 1'b1;
      wait_strobe(20, got);
      check($sformatf("burst_strobe[%0d]", k), 32'(got), 32'd1);
      check($sformatf("burst_txdata[%0d]", k), 32'(txdata), 32'h30 + 32'(k));
    end
    check("burst_drained", outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h37});

    // ---- 5: fast transmitter, timeout spacing ----
    do_reset();
    txready = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    step();
    wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    check("timeout_first", {16'h0, 7'h0, txclk, txdata}, {16'h0, 7'h0, 1'b1, 8'h55});
    t1 = cyc;
    wait_strobe(20, got);
    check("timeout_second_seen", 32'(got), 32'd1);
    check("timeout_spacing", 32'(cyc - t1), 32'(4 + BT));
    check("timeout_second_data", 32'(txdata), 32'hAA);
    nstrobe = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (txclk !== 1'b0) nstrobe++;
    end
    check("timeout_no_extra", 32'(nstrobe), 32'd0);

    // ---- 6: reset in WAIT_READY with 3 bytes queued ----
    do_reset();
    txready = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA0;
    step();
    wr_data = 8'hA1;
    step();
    check("midrst_strobe", {16'h0, 7'h0, txclk, txdata}, {16'h0, 7'h0, 1'b1, 8'hA0});
    txready = 1'b0;
    wr_data = 8'hA2;
    step();
    wr_data = 8'hA3;
    step();
    wr_en = 1'b0;
    step();
    check("midrst_queued", {16'h0, 7'h0, txclk, 4'h0, count}, {16'h0, 7'h0, 1'b0, 4'h0, 4'd3});
    #2;
    reset = 1'b0;
    #1;
    check("midrst_async", outs(), {16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    step();
    reset   = 1'b1;
    txready = 1'b1;
    nstrobe = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (txclk !== 1'b0) nstrobe++;
    end
    check("midrst_silent", 32'(nstrobe), 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    wait_strobe(5, got);
    check("midrst_new_strobe", 32'(got), 32'd1);
    check("midrst_new_data", 32'(txdata), 32'h77);

    // ---- randomized run against queue model ----
    do_reset();
    q.delete();
    ovf_m       = 1'b0;
    busy_left   = 0;
    last_strobe = -100;
    for (int c = 0; c < 800; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 200 && q.size() > 0; c++) rnd_cycle(1'b0);
    check("rnd_drained", 32'(q.size()), 32'd0);
    nstrobe = 0;
    for (int i = 0; i < 15; i++) begin
      rnd_cycle(1'b0);
    end
    check("rnd_final_empty", {31'h0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
